// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x oversampled tick aligned to each start
// edge, start-bit glitch rejection, 8N1 framing with valid / framing-error pulses.
module uart_rx #(
  parameter int unsigned FRE        = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TICK_MAX   = FRE / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned TICK_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX - 1);
  localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rx_s;
  logic              rx_prev;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        os_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tick;
  logic              fall;

  assign tick = (tick_cnt == TICK_LAST);
  assign fall = rx_prev & ~rx_s;

  // Synchroniser, edge history and free-running tick, re-phased at each frame start
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      tick_cnt <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if ((state == IDLE && fall) || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            os_cnt  <= '0;
            bit_idx <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == OS_MID) begin
              os_cnt  <= '0;
              bit_idx <= '0;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              shift_reg[bit_idx] <= rx_s;
              os_cnt             <= '0;
              bit_idx            <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          // Leave at stop-bit centre so a back-to-back start edge is not missed
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (rx_s) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                rx_frame_err <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
